// File: rtl/mix_batch_arbiter.sv
// Round-robin arbiter that shares one mixing tank controller between NREQ recipe requesters.
// Optional statistics counters (batch_cnt, fault_cnt) are enabled by defining MIX_BATCH_STATS_EN.
module mix_batch_arbiter #(
    parameter int NREQ = 4,
    parameter int WIDTH = 8,
    parameter int WDOG_W = 16,
    parameter logic [WDOG_W-1:0] WDOG_LIMIT = 16'hFFFF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     mix_time,
    input  logic [NREQ*WIDTH-1:0]     drain_time,
    input  logic                      tank_busy,
    input  logic                      tank_done,
    input  logic                      estop,
    input  logic                      fault_clr,
    output logic                      start,
    output logic [WIDTH-1:0]          mix_load,
    output logic [WIDTH-1:0]          drain_load,
    output logic [NREQ-1:0]           grant,
    output logic [$clog2(NREQ)-1:0]   active_id,
    output logic [NREQ-1:0]           batch_done,
    output logic                      fault
`ifdef MIX_BATCH_STATS_EN
    ,
    output logic [15:0]               batch_cnt,
    output logic [7:0]                fault_cnt
`endif
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [IDW-1:0]      ptr_r;
    logic [IDW-1:0]      id_r;
    logic [IDW-1:0]      pick_s;
    logic [WIDTH-1:0]    mix_lat_r;
    logic [WIDTH-1:0]    drain_lat_r;
    logic [WDOG_W-1:0]   wdog_r;
    logic [NREQ-1:0]     onehot_s;
    logic                kill_s;
    logic                owned_s;

    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IDW-1:0] p);
        logic [IDW-1:0] pick;
        logic           hit;
        int             idx;
        pick = p;
        hit  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(p) + i) % NREQ;
            if (!hit && r[idx]) begin
                hit  = 1'b1;
                pick = IDW'(idx);
            end
        end
        return pick;
    endfunction

    // Arbitration pick and output decode helpers
    always_comb begin
        pick_s   = rr_pick(req, ptr_r);
        onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << id_r;
        kill_s   = (state_s == ST_FAULT);
        owned_s  = (state_r == ST_START) || (state_r == ST_RUN) || (state_r == ST_DONE);
    end

    // Next-state logic; estop overrides every state
    always_comb begin
        state_s = state_r;
        if (estop) begin
            state_s = ST_FAULT;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!tank_busy && (req != {NREQ{1'b0}})) state_s = ST_START;
                    else                                      state_s = ST_IDLE;
                end
                ST_START: state_s = ST_RUN;
                ST_RUN: begin
                    if (tank_done)                                  state_s = ST_DONE;
                    else if (wdog_r == (WDOG_LIMIT - {{(WDOG_W-1){1'b0}}, 1'b1})) state_s = ST_FAULT;
                    else                                            state_s = ST_RUN;
                end
                ST_DONE: state_s = ST_IDLE;
                ST_FAULT: begin
                    if (fault_clr) state_s = ST_IDLE;
                    else           state_s = ST_FAULT;
                end
                default: state_s = ST_FAULT;
            endcase
        end
    end

    // State, batch context, watchdog and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            ptr_r       <= {IDW{1'b0}};
            id_r        <= {IDW{1'b0}};
            mix_lat_r   <= {WIDTH{1'b0}};
            drain_lat_r <= {WIDTH{1'b0}};
            wdog_r      <= {WDOG_W{1'b0}};
        end else begin
            state_r <= state_s;
            if ((state_r == ST_IDLE) && (state_s == ST_START)) begin
                id_r        <= pick_s;
                mix_lat_r   <= mix_time[int'(pick_s)*WIDTH +: WIDTH];
                drain_lat_r <= drain_time[int'(pick_s)*WIDTH +: WIDTH];
            end
            if (state_r == ST_START)    wdog_r <= {WDOG_W{1'b0}};
            else if (state_r == ST_RUN) wdog_r <= wdog_r + {{(WDOG_W-1){1'b0}}, 1'b1};
            // Pointer only advances on a completed batch, never through a fault
            if ((state_r == ST_DONE) && (state_s == ST_IDLE))
                ptr_r <= (id_r == IDW'(NREQ-1)) ? {IDW{1'b0}} : id_r + {{(IDW-1){1'b0}}, 1'b1};
        end
    end

    // Registered outputs; a pending fault suppresses start/grant/batch_done at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start      <= 1'b0;
            grant      <= {NREQ{1'b0}};
            batch_done <= {NREQ{1'b0}};
            mix_load   <= {WIDTH{1'b0}};
            drain_load <= {WIDTH{1'b0}};
            active_id  <= {IDW{1'b0}};
            fault      <= 1'b0;
        end else begin
            start      <= (state_r == ST_START) && !kill_s;
            grant      <= (owned_s && !kill_s) ? onehot_s : {NREQ{1'b0}};
            batch_done <= ((state_r == ST_DONE) && !kill_s) ? onehot_s : {NREQ{1'b0}};
            fault      <= kill_s;
            if ((state_r == ST_START) && !kill_s) begin
                active_id  <= id_r;
                mix_load   <= mix_lat_r;
                drain_load <= drain_lat_r;
            end
        end
    end

`ifdef MIX_BATCH_STATS_EN
    // Saturating statistics, cleared only by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            batch_cnt <= 16'd0;
            fault_cnt <= 8'd0;
        end else begin
            if ((state_r == ST_DONE) && !kill_s && (batch_cnt != 16'hFFFF))
                batch_cnt <= batch_cnt + 16'd1;
            if (kill_s && (state_r != ST_FAULT) && (fault_cnt != 8'hFF))
                fault_cnt <= fault_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mix_batch_arbiter.sv
// Self-checking bench for mix_batch_arbiter: directed scenarios plus random traffic against a reference model.
module tb_mix_batch_arbiter;

    localparam int NREQ = 4;
    localparam int WIDTH = 8;
    localparam int LIMIT = 10;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] mix_time = '0;
    logic [NREQ*WIDTH-1:0] drain_time = '0;
    logic                  tank_busy = 1'b0;
    logic                  tank_done = 1'b0;
    logic                  estop = 1'b0;
    logic                  fault_clr = 1'b0;
    logic                  start;
    logic [WIDTH-1:0]      mix_load;
    logic [WIDTH-1:0]      drain_load;
    logic [NREQ-1:0]       grant;
    logic [1:0]            active_id;
    logic [NREQ-1:0]       batch_done;
    logic                  fault;
`ifdef MIX_BATCH_STATS_EN
    logic [15:0]           batch_cnt;
    logic [7:0]            fault_cnt;
`endif

    int n_tests = 0;
    int n_fail = 0;

    mix_batch_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .WDOG_W(16), .WDOG_LIMIT(16'd10)) dut (
        .clk(clk), .rst(rst), .req(req), .mix_time(mix_time), .drain_time(drain_time),
        .tank_busy(tank_busy), .tank_done(tank_done), .estop(estop), .fault_clr(fault_clr),
        .start(start), .mix_load(mix_load), .drain_load(drain_load), .grant(grant),
        .active_id(active_id), .batch_done(batch_done), .fault(fault)
`ifdef MIX_BATCH_STATS_EN
        , .batch_cnt(batch_cnt), .fault_cnt(fault_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: phase of the tank session plus the expected visible outputs
    int   phase;          // 0 waiting, 1 starting, 2 running, 3 finishing, 4 faulted
    int   next_turn;      // requester that gets first look at the next arbitration
    int   owner;
    int   run_cycles;
    logic [7:0] owner_mix, owner_drain;
    logic       e_start, e_fault;
    logic [3:0] e_grant, e_bd;
    logic [1:0] e_id;
    logic [7:0] e_mix, e_drain;
    int         e_bcnt, e_fcnt;

    task automatic model_reset();
        phase = 0; next_turn = 0; owner = 0; run_cycles = 0;
        owner_mix = 8'h00; owner_drain = 8'h00;
        e_start = 1'b0; e_fault = 1'b0; e_grant = 4'h0; e_bd = 4'h0;
        e_id = 2'd0; e_mix = 8'h00; e_drain = 8'h00; e_bcnt = 0; e_fcnt = 0;
    endtask

    task automatic model_step();
        int  nxt;
        bit  killed;
        nxt = phase;
        if (estop) nxt = 4;
        else if (phase == 0 && !tank_busy && req != 4'h0) nxt = 1;
        else if (phase == 1) nxt = 2;
        else if (phase == 2 && tank_done) nxt = 3;
        else if (phase == 2 && run_cycles == LIMIT - 1) nxt = 4;
        else if (phase == 3) nxt = 0;
        else if (phase == 4 && fault_clr) nxt = 0;
        killed  = (nxt == 4);
        e_fault = killed;
        e_start = (phase == 1) && !killed;
        e_grant = (phase >= 1 && phase <= 3 && !killed) ? 4'(1 << owner) : 4'h0;
        e_bd    = (phase == 3 && !killed) ? 4'(1 << owner) : 4'h0;
        if (phase == 1 && !killed) begin
            e_id = 2'(owner); e_mix = owner_mix; e_drain = owner_drain;
        end
        if (phase == 3 && !killed && e_bcnt < 65535) e_bcnt++;
        if (killed && phase != 4 && e_fcnt < 255) e_fcnt++;
        if (phase == 1) run_cycles = 0;
        else if (phase == 2) run_cycles++;
        if (phase == 3 && nxt == 0) next_turn = (owner + 1) % NREQ;
        if (phase == 0 && nxt == 1) begin
            for (int k = NREQ - 1; k >= 0; k--)
                if (req[(next_turn + k) % NREQ]) owner = (next_turn + k) % NREQ;
            owner_mix   = mix_time[owner*WIDTH +: WIDTH];
            owner_drain = drain_time[owner*WIDTH +: WIDTH];
        end
        phase = nxt;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("start", 32'(start), 32'(e_start));
        chk("grant", 32'(grant), 32'(e_grant));
        chk("active_id", 32'(active_id), 32'(e_id));
        chk("mix_load", 32'(mix_load), 32'(e_mix));
        chk("drain_load", 32'(drain_load), 32'(e_drain));
        chk("batch_done", 32'(batch_done), 32'(e_bd));
        chk("fault", 32'(fault), 32'(e_fault));
        chk("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
`ifdef MIX_BATCH_STATS_EN
        chk("batch_cnt", 32'(batch_cnt), 32'(e_bcnt));
        chk("fault_cnt", 32'(fault_cnt), 32'(e_fcnt));
`endif
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'h0; tank_done = 1'b0; estop = 1'b0; fault_clr = 1'b0; tank_busy = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_batch(input logic [3:0] r);
        req = r; cyc(); cyc(); req = 4'h0; cyc();
        tank_done = 1'b1; cyc(); tank_done = 1'b0; cyc(); cyc();
    endtask

    initial begin
        int order [5];
        int cnt;
        @(negedge clk);
        do_reset();

        // Single batch for requester 1
        mix_time[1*WIDTH +: WIDTH] = 8'h20;
        drain_time[1*WIDTH +: WIDTH] = 8'h10;
        req = 4'b0010;
        cyc(); cyc();
        chk("t1_start", 32'(start), 32'd1);
        chk("t1_grant", 32'(grant), 32'h2);
        chk("t1_id", 32'(active_id), 32'd1);
        chk("t1_mix", 32'(mix_load), 32'h20);
        chk("t1_drain", 32'(drain_load), 32'h10);
        req = 4'h0;
        cyc();
        chk("t1_start_pulse", 32'(start), 32'd0);
        tank_done = 1'b1; cyc(); tank_done = 1'b0; cyc();
        chk("t1_batch_done", 32'(batch_done), 32'h2);
        cyc();
        chk("t1_grant_clear", 32'(grant), 32'h0);

        // Round-robin order with all requesters pending
        do_reset();
        req = 4'b1111;
        for (int b = 0; b < 5; b++) begin
            cnt = 0;
            do begin cyc(); cnt++; end while (!start && cnt < 20);
            chk("rr_start_seen", 32'(start), 32'd1);
            order[b] = int'(active_id);
            repeat (4) cyc();
            tank_done = 1'b1; cyc(); tank_done = 1'b0;
        end
        chk("rr_order0", 32'(order[0]), 32'd0);
        chk("rr_order1", 32'(order[1]), 32'd1);
        chk("rr_order2", 32'(order[2]), 32'd2);
        chk("rr_order3", 32'(order[3]), 32'd3);
        chk("rr_order4", 32'(order[4]), 32'd0);

        // Watchdog expiry with no tank_done
        req = 4'h0; cyc(); cyc(); cyc();
        do_reset();
        req = 4'b0001;
        cyc(); cyc();
        req = 4'h0;
        cnt = 0;
        do begin cyc(); cnt++; end while (!fault && cnt < 30);
        chk("wd_cycles", 32'(cnt), 32'(LIMIT));
        chk("wd_grant", 32'(grant), 32'h0);
        req = 4'b1110; fault_clr = 1'b1; cyc();
        chk("wd_clear", 32'(fault), 32'd0);
        fault_clr = 1'b0; cyc(); cyc();
        chk("wd_next_id", 32'(active_id), 32'd1);
        req = 4'h0; tank_done = 1'b1; cyc(); tank_done = 1'b0; cyc(); cyc();

        // Emergency stop in the middle of a batch
        do_reset();
        req = 4'b0100; cyc(); cyc();
        chk("es_grant", 32'(grant), 32'h4);
        req = 4'h0; cyc(); cyc();
        estop = 1'b1; cyc();
        chk("es_fault", 32'(fault), 32'd1);
        chk("es_grant0", 32'(grant), 32'h0);
        chk("es_no_done", 32'(batch_done), 32'h0);
        fault_clr = 1'b1; cyc();
        chk("es_hold", 32'(fault), 32'd1);
        estop = 1'b0; cyc();
        chk("es_exit", 32'(fault), 32'd0);
        fault_clr = 1'b0; cyc();

        // tank_done coincident with watchdog expiry, then tank_busy gating
        do_reset();
        req = 4'b0001; cyc(); cyc(); req = 4'h0;
        cnt = 0;
        while (run_cycles != LIMIT - 1 && cnt < 30) begin cyc(); cnt++; end
        tank_done = 1'b1; cyc(); tank_done = 1'b0; cyc();
        chk("tie_done", 32'(batch_done), 32'h1);
        chk("tie_fault", 32'(fault), 32'd0);
        cyc();
        req = 4'b0010; tank_busy = 1'b1;
        repeat (5) begin cyc(); chk("busy_nostart", 32'(start), 32'd0); end
        tank_busy = 1'b0; cyc(); cyc();
        chk("busy_start", 32'(start), 32'd1);
        req = 4'h0; tank_done = 1'b1; cyc(); tank_done = 1'b0; cyc(); cyc();

        // Statistics: three batches and one estop
        do_reset();
        run_batch(4'b0001); run_batch(4'b0010); run_batch(4'b1000);
        estop = 1'b1; cyc(); estop = 1'b0; fault_clr = 1'b1; cyc(); fault_clr = 1'b0; cyc();
`ifdef MIX_BATCH_STATS_EN
        chk("stat_batch", 32'(batch_cnt), 32'd3);
        chk("stat_fault", 32'(fault_cnt), 32'd1);
        do_reset();
        chk("stat_batch_rst", 32'(batch_cnt), 32'd0);
        chk("stat_fault_rst", 32'(fault_cnt), 32'd0);
`endif

        // Random traffic against the model, with one reset mid-stream
        for (int i = 0; i < 400; i++) begin
            req        = 4'($urandom);
            mix_time   = $urandom;
            drain_time = $urandom;
            tank_busy  = ($urandom_range(0, 7) == 0);
            tank_done  = ($urandom_range(0, 4) == 0);
            estop      = ($urandom_range(0, 60) == 0);
            fault_clr  = ($urandom_range(0, 3) == 0);
            if (i == 200) do_reset();
            else cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mix_batch_arbiter.md
Name: mix_batch_arbiter

Overview:
- Shares one mixing tank controller between NREQ recipe requesters.
- Arbitrates round-robin and latches the winner's mix and drain durations for the tank controller's duration counter.
- Issues a single start pulse, then waits for the batch to finish under a watchdog.
- Returns a completion pulse to the winning requester. Emergency stop and watchdog expiry force a sticky fault.

Parameters:
- NREQ, 4, number of requester channels (2..8)
- WIDTH, 8, width of mix/drain duration values
- WDOG_W, 16, watchdog counter width
- WDOG_LIMIT, 16'hFFFF, RUN-state cycles allowed before fault (must be >= 1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req  in  NREQ  level request per requester; bit i = requester i
- mix_time  in  NREQ*WIDTH  per-requester mix duration; slice i = bits [i*WIDTH +: WIDTH]
- drain_time  in  NREQ*WIDTH  per-requester drain duration, same packing
- tank_busy  in  1  tank controller not in its idle state
- tank_done  in  1  one-cycle pulse, batch complete
- estop  in  1  emergency stop, level
- fault_clr  in  1  operator fault acknowledge, level
- start  out  1  one-cycle start to tank controller
- mix_load  out  WIDTH  latched mix duration of active batch
- drain_load  out  WIDTH  latched drain duration of active batch
- grant  out  NREQ  one-hot grant, held for whole batch
- active_id  out  $clog2(NREQ)  index of granted requester
- batch_done  out  NREQ  one-cycle completion pulse to granted requester
- fault  out  1  sticky fault flag

Behaviour:
- All outputs are registered.
- Reset values: start=0, grant=0, batch_done=0, mix_load=0, drain_load=0, active_id=0, fault=0. Round-robin pointer resets to 0, state resets to IDLE, watchdog resets to 0.
- Reset mid-batch aborts immediately to these values; no batch_done is issued.
- States: IDLE, START, RUN, DONE, FAULT.
- estop=1 in any state: next state FAULT on the following edge. estop has highest priority.
- IDLE:
  - If req!=0 and tank_busy=0, select the first set bit scanning upward from the pointer, wrapping modulo NREQ.
  - Latch id, mix_time slice and drain_time slice; go to START.
  - If tank_busy=1, hold in IDLE regardless of req.
- START (exactly 1 cycle):
  - start=1, grant=onehot(id), active_id=id.
  - mix_load/drain_load valid now and held until the next grant.
  - Watchdog cleared. Next state RUN.
- Latency: req sampled in IDLE at edge n gives start and grant visible after edge n+1.
- RUN:
  - grant held. Watchdog increments each cycle.
  - tank_done=1 -> DONE.
  - Otherwise, watchdog == WDOG_LIMIT-1 -> FAULT.
  - If tank_done and expiry occur in the same cycle, tank_done wins.
  - Deasserting req[id] during RUN has no effect; the batch runs to completion.
- DONE (1 cycle):
  - batch_done[id]=1, grant still held.
  - Pointer <= (id+1) mod NREQ. Next state IDLE, where grant clears.
  - The earliest next start is 2 cycles after DONE.
- tank_done outside RUN is ignored.
- FAULT:
  - fault=1, grant=0, start=0, batch_done=0. Pointer preserved.
  - Exit to IDLE only when fault_clr=1 and estop=0 in the same cycle; fault clears on that exit edge.
- Zero-valued durations are passed through unchanged; the arbiter does not validate recipes.
- Only one grant bit may ever be set. grant=0 in IDLE and FAULT.

Optional Feature:
- Macro: MIX_BATCH_STATS_EN.
- When defined, adds two outputs:
  - batch_cnt [15:0]: increments on each DONE, saturates at 16'hFFFF.
  - fault_cnt [7:0]: increments on each entry to FAULT, saturates at 8'hFF.
  - Both reset to 0 on rst only; fault_clr does not clear them.
- When undefined, both ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then req=4'b0010, mix_time[1]=8'h20, drain_time[1]=8'h10, tank_busy=0 -> one cycle later start=1 for 1 cycle, grant=4'b0010, active_id=1, mix_load=8'h20, drain_load=8'h10. tank_done pulse -> batch_done=4'b0010 for 1 cycle, then grant=0.
- req=4'b1111 held, tank_done returned 5 cycles after each start -> grants in order 0,1,2,3,0; exactly one grant bit set at all times.
- WDOG_LIMIT=16'd10, grant 0, no tank_done -> fault=1 after 10 RUN cycles, grant=0. fault_clr=1 with estop=0 -> IDLE next cycle, and the next grant goes to requester 1.
- estop asserted mid-RUN (grant=4'b0100) -> next cycle fault=1, grant=0, no batch_done. fault_clr while estop=1 -> stays FAULT. Release estop with fault_clr -> IDLE.
- tank_done asserted in the same cycle the watchdog expires -> DONE with batch_done pulse, fault stays 0. tank_busy=1 with req pending -> no start until tank_busy=0.
- MIX_BATCH_STATS_EN defined: 3 completed batches plus 1 estop -> batch_cnt=3, fault_cnt=1. rst -> both 0.
